// File: rtl/microseq.sv
// Microprogram sequencer for the 65C02 core.
// Computes the next 9-bit microcode ROM address from the current microword's
// sequencing fields, the opcode, the status flags and the interrupt request.
// Holds the current microaddress and a 2-entry micro-subroutine return stack.
module microseq #(
  parameter logic [8:0]  RESET_ADDR  = 9'h170,
  parameter logic [8:0]  IRQ_ADDR    = 9'h1F0,
  parameter int unsigned STACK_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rdy,
  input  logic [2:0] seq_op,
  input  logic [8:0] seq_target,
  input  logic [2:0] cond_sel,
  input  logic       cond_inv,
  input  logic [7:0] flags,
  input  logic [7:0] opcode,
  input  logic       irq,
  output logic [8:0] rom_addr,
  output logic       rom_en,
  output logic [8:0] upc,
  output logic       stack_err
);

  // Only a 2-deep stack is supported; depth saturates at this value.
  localparam logic [1:0] MaxDepth = 2'(STACK_DEPTH);

  localparam logic [2:0] OpNext   = 3'd0;
  localparam logic [2:0] OpJump   = 3'd1;
  localparam logic [2:0] OpBranch = 3'd2;
  localparam logic [2:0] OpCall   = 3'd3;
  localparam logic [2:0] OpRet    = 3'd4;
  localparam logic [2:0] OpDecode = 3'd5;

  logic [8:0] r_upc;
  logic [8:0] r_stk_top;
  logic [8:0] r_stk_bot;
  logic [1:0] r_depth;
  logic       r_stack_err;

  logic [8:0] w_upc_inc;
  logic       w_cond;
  logic [8:0] w_next;
  logic       w_push;
  logic       w_pop;
  logic       w_err_set;

  // Next-address selection and stack control decoded from the sequencing op.
  always_comb begin
    w_upc_inc = r_upc + 9'd1;
    w_cond    = flags[cond_sel] ^ cond_inv;
    w_next    = r_upc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    case (seq_op)
      OpNext:   w_next = w_upc_inc;
      OpJump:   w_next = seq_target;
      OpBranch: w_next = w_cond ? seq_target : w_upc_inc;
      OpCall: begin
        w_next    = seq_target;
        w_push    = 1'b1;
        w_err_set = (r_depth == MaxDepth);
      end
      OpRet: begin
        w_pop = 1'b1;
        if (r_depth == 2'd0) begin
          // Underflow: restart the machine rather than return to garbage.
          w_next    = RESET_ADDR;
          w_err_set = 1'b1;
        end else begin
          w_next = r_stk_top;
        end
      end
      OpDecode: w_next = irq ? IRQ_ADDR : {1'b0, opcode};
      default:  w_next = r_upc;
    endcase
  end

  // ROM interface: reset address while in reset, current address while stalled.
  always_comb begin
    if (!reset) begin
      rom_addr = RESET_ADDR;
    end else if (!rdy) begin
      rom_addr = r_upc;
    end else begin
      rom_addr = w_next;
    end
    rom_en    = rdy & reset;
    upc       = r_upc;
    stack_err = r_stack_err;
  end

  // Microaddress, return stack and sticky error; frozen while rdy is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_upc       <= RESET_ADDR;
      r_stk_top   <= 9'h000;
      r_stk_bot   <= 9'h000;
      r_depth     <= 2'd0;
      r_stack_err <= 1'b0;
    end else if (rdy) begin
      r_upc       <= w_next;
      r_stack_err <= r_stack_err | w_err_set;
      if (w_push) begin
        // At full depth the shift discards the bottom entry.
        r_stk_bot <= r_stk_top;
        r_stk_top <= w_upc_inc;
        if (r_depth != MaxDepth) begin
          r_depth <= r_depth + 2'd1;
        end
      end else if (w_pop && (r_depth != 2'd0)) begin
        r_stk_top <= r_stk_bot;
        r_stk_bot <= 9'h000;
        r_depth   <= r_depth - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_microseq.sv
// Scoreboard bench for microseq: stimulus pushes expected outputs into a
// queue, a negedge monitor pops and compares against the DUT.
module tb_microseq;

  logic       clk;
  logic       reset;
  logic       rdy;
  logic [2:0] seq_op;
  logic [8:0] seq_target;
  logic [2:0] cond_sel;
  logic       cond_inv;
  logic [7:0] flags;
  logic [7:0] opcode;
  logic       irq;
  logic [8:0] rom_addr;
  logic       rom_en;
  logic [8:0] upc;
  logic       stack_err;

  typedef struct {
    string      name;
    logic [8:0] addr;
    logic       en;
    logic [8:0] upc;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BRANCH = 3'd2, CALL = 3'd3,
                         RET = 3'd4, DECODE = 3'd5, HOLD6 = 3'd6, HOLD7 = 3'd7;

  microseq dut (
    .clk        (clk),
    .reset      (reset),
    .rdy        (rdy),
    .seq_op     (seq_op),
    .seq_target (seq_target),
    .cond_sel   (cond_sel),
    .cond_inv   (cond_inv),
    .flags      (flags),
    .opcode     (opcode),
    .irq        (irq),
    .rom_addr   (rom_addr),
    .rom_en     (rom_en),
    .upc        (upc),
    .stack_err  (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one microword at posedge+1, queue the expectation, advance a cycle.
  task automatic step(input string name, input logic rst, input logic r,
                      input logic [2:0] op, input logic [8:0] tgt,
                      input logic [2:0] cs, input logic ci,
                      input logic [7:0] opc, input logic iq,
                      input logic [8:0] e_addr, input logic e_en,
                      input logic [8:0] e_upc, input logic e_err);
    exp_t e;
    reset      = rst;
    rdy        = r;
    seq_op     = op;
    seq_target = tgt;
    cond_sel   = cs;
    cond_inv   = ci;
    opcode     = opc;
    irq        = iq;
    e.name = name;
    e.addr = e_addr;
    e.en   = e_en;
    e.upc  = e_upc;
    e.err  = e_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (rom_addr !== e.addr) begin
        failures++;
        $display("FAIL %s rom_addr got=%h exp=%h", e.name, rom_addr, e.addr);
      end
      checks++;
      if (rom_en !== e.en) begin
        failures++;
        $display("FAIL %s rom_en got=%b exp=%b", e.name, rom_en, e.en);
      end
      checks++;
      if (upc !== e.upc) begin
        failures++;
        $display("FAIL %s upc got=%h exp=%h", e.name, upc, e.upc);
      end
      checks++;
      if (stack_err !== e.err) begin
        failures++;
        $display("FAIL %s stack_err got=%b exp=%b", e.name, stack_err, e.err);
      end
    end
  end

  initial begin
    int waited;
    reset      = 1'b0;
    rdy        = 1'b1;
    seq_op     = JUMP;
    seq_target = 9'h170;
    cond_sel   = 3'd0;
    cond_inv   = 1'b0;
    flags      = 8'b0000_0101;
    opcode     = 8'h00;
    irq        = 1'b0;
    @(posedge clk);
    #1;

    //   name          rst rdy op      tgt     cs   ci  opc    irq  addr   en   upc    err
    step("in_reset",   0, 1, JUMP,   9'h170, 0, 0, 8'h00, 0, 9'h170, 0, 9'h170, 0);
    step("rel_reset",  1, 1, JUMP,   9'h170, 0, 0, 8'h00, 0, 9'h170, 1, 9'h170, 0);
    step("jump_1ff",   1, 1, JUMP,   9'h1FF, 0, 0, 8'h00, 0, 9'h1FF, 1, 9'h170, 0);
    step("next_wrap",  1, 1, NEXT,   9'h000, 0, 0, 8'h00, 0, 9'h000, 1, 9'h1FF, 0);
    step("br_taken",   1, 1, BRANCH, 9'h0A0, 0, 0, 8'h00, 0, 9'h0A0, 1, 9'h000, 0);
    step("br_inv",     1, 1, BRANCH, 9'h0C0, 0, 1, 8'h00, 0, 9'h0A1, 1, 9'h0A0, 0);
    step("br_bit1",    1, 1, BRANCH, 9'h0C0, 1, 0, 8'h00, 0, 9'h0A2, 1, 9'h0A1, 0);
    step("br_bit2",    1, 1, BRANCH, 9'h0C0, 2, 0, 8'h00, 0, 9'h0C0, 1, 9'h0A2, 0);
    step("jump_010",   1, 1, JUMP,   9'h010, 0, 0, 8'h00, 0, 9'h010, 1, 9'h0C0, 0);
    step("call_050",   1, 1, CALL,   9'h050, 0, 0, 8'h00, 0, 9'h050, 1, 9'h010, 0);
    step("call_stall", 1, 0, CALL,   9'h060, 0, 0, 8'h00, 0, 9'h050, 0, 9'h050, 0);
    step("call_060",   1, 1, CALL,   9'h060, 0, 0, 8'h00, 0, 9'h060, 1, 9'h050, 0);
    step("ret_051",    1, 1, RET,    9'h000, 0, 0, 8'h00, 0, 9'h051, 1, 9'h060, 0);
    step("ret_011",    1, 1, RET,    9'h000, 0, 0, 8'h00, 0, 9'h011, 1, 9'h051, 0);
    step("ncall1",     1, 1, CALL,   9'h100, 0, 0, 8'h00, 0, 9'h100, 1, 9'h011, 0);
    step("ncall2",     1, 1, CALL,   9'h110, 0, 0, 8'h00, 0, 9'h110, 1, 9'h100, 0);
    step("ncall3",     1, 1, CALL,   9'h120, 0, 0, 8'h00, 0, 9'h120, 1, 9'h110, 0);
    step("nret1",      1, 1, RET,    9'h000, 0, 0, 8'h00, 0, 9'h111, 1, 9'h120, 1);
    step("nret2",      1, 1, RET,    9'h000, 0, 0, 8'h00, 0, 9'h101, 1, 9'h111, 1);
    step("nret3_udf",  1, 1, RET,    9'h000, 0, 0, 8'h00, 0, 9'h170, 1, 9'h101, 1);
    step("err_sticky", 1, 1, NEXT,   9'h000, 0, 0, 8'h00, 0, 9'h171, 1, 9'h170, 1);
    step("dec_a9",     1, 1, DECODE, 9'h000, 0, 0, 8'hA9, 0, 9'h0A9, 1, 9'h171, 1);
    step("dec_irq",    1, 1, DECODE, 9'h000, 0, 0, 8'hA9, 1, 9'h1F0, 1, 9'h0A9, 1);
    step("next_irq",   1, 1, NEXT,   9'h000, 0, 0, 8'hA9, 1, 9'h1F1, 1, 9'h1F0, 1);
    step("hold6",      1, 1, HOLD6,  9'h055, 0, 0, 8'h00, 0, 9'h1F1, 1, 9'h1F1, 1);
    step("hold7",      1, 1, HOLD7,  9'h055, 0, 0, 8'h00, 0, 9'h1F1, 1, 9'h1F1, 1);
    step("jump_020",   1, 1, JUMP,   9'h020, 0, 0, 8'h00, 0, 9'h020, 1, 9'h1F1, 1);
    step("stall1",     1, 0, CALL,   9'h030, 0, 0, 8'h00, 0, 9'h020, 0, 9'h020, 1);
    step("stall2",     1, 0, CALL,   9'h030, 0, 0, 8'h00, 1, 9'h020, 0, 9'h020, 1);
    // Reset lands between edges while still stalled: effect must be immediate.
    step("stall_rst",  0, 0, CALL,   9'h030, 0, 0, 8'h00, 0, 9'h170, 0, 9'h170, 0);
    step("rst_rel2",   1, 1, JUMP,   9'h170, 0, 0, 8'h00, 0, 9'h170, 1, 9'h170, 0);
    // Depth must be 0 after reset: a RET underflows to the reset routine.
    step("ret_empty",  1, 1, RET,    9'h000, 0, 0, 8'h00, 0, 9'h170, 1, 9'h170, 0);
    step("err_again",  1, 1, NEXT,   9'h000, 0, 0, 8'h00, 0, 9'h171, 1, 9'h170, 1);

    waited = 0;
    while (exp_q.size() > 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain queue_left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/microseq.md
Name: microseq

Overview:
- Microprogram sequencer for the 65C02 core. Sits directly upstream of the microcode ROM.
- Each cycle it computes the 9-bit ROM address from the current microword's sequencing fields, the opcode, status flags and the interrupt request.
- Keeps the current microaddress and a 2-entry microsubroutine return stack.
- Drives the ROM enable so the core stalls cleanly while memory is not ready.

Parameters:
- RESET_ADDR, 9'h170, microaddress of the reset routine (matches the ROM's reset/SRVAL word).
- IRQ_ADDR, 9'h1F0, microaddress of the interrupt entry routine.
- STACK_DEPTH, 2, number of return-stack entries (fixed at 2; other values unsupported).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rdy  input  1  memory ready; low stalls the sequencer.
- seq_op  input  3  sequencing op from the current microword: 0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 DECODE, 6/7 HOLD.
- seq_target  input  9  jump/branch/call target from the current microword.
- cond_sel  input  3  selects one bit of flags.
- cond_inv  input  1  inverts the selected condition.
- flags  input  8  condition inputs (bit 0 is tied high by the integrator, giving "always").
- opcode  input  8  latched instruction opcode.
- irq  input  1  interrupt pending, sampled only on DECODE.
- rom_addr  output  9  next microaddress, to ROM address input.
- rom_en  output  1  ROM enable.
- upc  output  9  current microaddress (debug/trace).
- stack_err  output  1  sticky stack overflow/underflow flag.

Behaviour:
- rom_addr is combinational from the registered upc, the stack and the microword fields.
- The ROM registers the address, so the microword for rom_addr is valid one cycle later.
- rom_en = rdy.
- Next-address by seq_op, evaluated with cond = flags[cond_sel] ^ cond_inv:
  - NEXT: upc+1. Wraps 9'h1FF -> 9'h000, no error.
  - JUMP: seq_target.
  - BRANCH: seq_target if cond, else upc+1.
  - CALL: seq_target. Pushes upc+1.
  - RET: top of stack. Pops.
  - DECODE: {1'b0, opcode} if irq==0, else IRQ_ADDR.
  - HOLD (6, 7): upc.
- Stall: while rdy==0, rom_addr = upc and nothing updates (upc, stack, depth, stack_err).
  - The ROM holds its output because enable is low.
- Register update when rdy==1: upc <= rom_addr. Stack and depth update per op.
- Stack: 2 entries, depth counter 0..2.
  - CALL at depth 2: bottom entry discarded, new entry pushed, depth stays 2, stack_err set.
  - RET at depth 0: rom_addr = RESET_ADDR, depth stays 0, stack_err set.
- stack_err is sticky. Cleared only by reset.
- Reset (reset low, asynchronous, any time including mid-stall or mid-CALL):
  - upc = RESET_ADDR.
  - depth = 0, stack entries = 9'h000.
  - stack_err = 0.
  - While reset is asserted: rom_addr = RESET_ADDR, rom_en = 0.
- First cycle after reset release:
  - The ROM still outputs its reset word (JUMP RESET_ADDR), so the sequencer issues RESET_ADDR again.
  - Execution starts at RESET_ADDR.
- Simultaneous events: irq is ignored on every op except DECODE. irq during a stall is sampled only on the first DECODE cycle with rdy==1.

Test Plan:
- Release reset with the ROM model returning JUMP 9'h170 -> rom_addr 9'h170 during and after reset. upc 9'h170. rom_en 0 during reset, 1 after. stack_err 0.
- upc=9'h1FF, op NEXT -> rom_addr 9'h000, stack_err stays 0. BRANCH target 9'h0A0 with cond_sel=0, cond_inv=0 -> 9'h0A0. With cond_inv=1 -> upc+1.
- CALL 9'h050 from upc 9'h010, then CALL 9'h060, then RET, RET -> addresses 050, 060, 052? No — expected sequence: 050, 060, then RET->9'h051, RET->9'h011. stack_err 0.
- Three nested CALLs then three RETs -> third CALL sets stack_err=1. Third RET yields RESET_ADDR. stack_err stays 1 until reset.
- DECODE with opcode 8'hA9, irq=0 -> 9'h0A9. Same with irq=1 -> 9'h1F0. irq=1 on a NEXT -> ignored.
- rdy low for 3 cycles during CALL, with reset pulsed low mid-stall -> upc, stack and depth frozen during the stall. Reset forces upc 9'h170 and depth 0 immediately (asynchronously), with no push recorded.
